// File: rtl/ads131_spi_responder_if.sv
// SPI bus between the ADS131A0X host (master) and the device-side responder (slave).
interface ads131_spi_responder_if;
    logic SPI_SCLK;
    logic SPI_CS;
    logic SPI_MOSI;
    logic SPI_MISO;

    modport master (output SPI_SCLK, output SPI_CS, output SPI_MOSI, input SPI_MISO);
    modport slave  (input SPI_SCLK, input SPI_CS, input SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/ads131_spi_responder.sv
// Device-side model of the ADS131A0X SPI data interface: oversamples the bus on
// system_clock, captures the command word and returns response + channel words.
module ads131_spi_responder #(
    parameter int WORD_BITS   = 32,
    parameter int FRAME_WORDS = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             system_clock,
    input  logic                             reset_n,
    ads131_spi_responder_if.slave            spi,
    input  logic [15:0]                      status_word,
    input  logic [(FRAME_WORDS-1)*24-1:0]    ch_data,
    output logic [15:0]                      rx_cmd,
    output logic                             rx_cmd_valid,
    output logic                             frame_done,
    output logic                             frame_error,
    output logic                             busy,
    output logic [1:0]                       state
);

    localparam int TOT_BITS = FRAME_WORDS * WORD_BITS;
    localparam int CNT_W    = $clog2(TOT_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOT_BITS);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // NULL and unknown commands fall through to the status word latched at frame start.
    function automatic logic [15:0] resp_map(input logic [15:0] cmd, input logic [15:0] stat);
        logic [15:0] r;
        case (cmd)
            16'h0011:                               r = 16'hFF04;
            16'h0655, 16'h0555, 16'h0022, 16'h0033: r = cmd;
            16'h0000:                               r = stat;
            default:                                r = stat;
        endcase
        return r;
    endfunction

    // bit 2 = SCLK, bit 1 = CS, bit 0 = MOSI
    logic [2:0]            sync_q [SYNC_STAGES];
    logic [1:0]            hist_q;
    state_e                state_q,       state_d;
    logic [TOT_BITS-1:0]   tx_q,          tx_d;
    logic [WORD_BITS-1:0]  rx_q,          rx_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic                  miso_q,        miso_d;
    logic [15:0]           rx_cmd_q,      rx_cmd_d;
    logic                  valid_q,       valid_d;
    logic                  done_q,        done_d;
    logic                  err_q,         err_d;
    logic [15:0]           resp_q,        resp_d;
    logic [15:0]           resp_next_q,   resp_next_d;
    logic [15:0]           status_lat_q,  status_lat_d;
    logic [TOT_BITS-1:0]   tx_load_s;
    logic                  sclk_s, cs_s, mosi_s;
    logic                  sclk_rise_s, sclk_fall_s, cs_rise_s;

    assign sclk_s      = sync_q[SYNC_STAGES-1][2];
    assign cs_s        = sync_q[SYNC_STAGES-1][1];
    assign mosi_s      = sync_q[SYNC_STAGES-1][0];
    assign sclk_rise_s = sclk_s & ~hist_q[1];
    assign sclk_fall_s = ~sclk_s & hist_q[1];
    assign cs_rise_s   = cs_s & ~hist_q[0];

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b010;
            end
            hist_q <= 2'b01;
        end else begin
            sync_q[0] <= {spi.SPI_SCLK, spi.SPI_CS, spi.SPI_MOSI};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= {sclk_s, cs_s};
        end
    end

    // Frame image: response word then one word per channel, left-justified.
    always_comb begin
        tx_load_s = '0;
        tx_load_s[TOT_BITS-1 -: 16] = resp_q;
        for (int k = 0; k < FRAME_WORDS - 1; k++) begin
            tx_load_s[TOT_BITS-1-(k+1)*WORD_BITS -: 24] = ch_data[24*k +: 24];
        end
    end

    // FSM and datapath next-state logic; a CS edge outranks any coincident SCLK edge.
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        rx_cmd_d     = rx_cmd_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        resp_d       = resp_q;
        resp_next_d  = resp_next_q;
        status_lat_d = status_lat_q;
        case (state_q)
            ST_IDLE: begin
                // Level test so a CS fall coinciding with DONE is still honoured.
                if (!cs_s) begin
                    tx_d         = tx_load_s;
                    rx_d         = '0;
                    cnt_d        = '0;
                    status_lat_d = status_word;
                    state_d      = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_d = ST_DONE;
                end else if (sclk_rise_s) begin
                    miso_d = tx_q[TOT_BITS-1];
                    tx_d   = {tx_q[TOT_BITS-2:0], 1'b0};
                end else if (sclk_fall_s && (cnt_q != FULL_CNT)) begin
                    rx_d  = {rx_q[WORD_BITS-2:0], mosi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == WORD_CNT) begin
                        rx_cmd_d    = rx_d[WORD_BITS-1 -: 16];
                        valid_d     = 1'b1;
                        resp_next_d = resp_map(rx_d[WORD_BITS-1 -: 16], status_lat_q);
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                if (cnt_q == FULL_CNT) begin
                    done_d = 1'b1;
                    resp_d = resp_next_q;
                end else begin
                    err_d = 1'b1;
                end
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            cnt_q        <= '0;
            miso_q       <= 1'b0;
            rx_cmd_q     <= 16'h0000;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            resp_q       <= 16'hFF04;
            resp_next_q  <= 16'hFF04;
            status_lat_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            rx_cmd_q     <= rx_cmd_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            resp_q       <= resp_d;
            resp_next_q  <= resp_next_d;
            status_lat_q <= status_lat_d;
        end
    end

    assign spi.SPI_MISO = miso_q;
    assign rx_cmd       = rx_cmd_q;
    assign rx_cmd_valid = valid_q;
    assign frame_done   = done_q;
    assign frame_error  = err_q;
    assign busy         = (state_q == ST_ACTIVE);
    assign state        = state_q;

endmodule

// File: tb/tb_ads131_spi_responder.sv
// Directed + randomized frames against a word-level model of the ADS131A0X responder.
module tb_ads131_spi_responder;

    localparam int WB   = 32;
    localparam int FW   = 5;
    localparam int TOT  = WB * FW;
    localparam int HALF = 6;

    logic        system_clock = 1'b0;
    logic        reset_n      = 1'b0;
    logic [15:0] status_word  = 16'h0000;
    logic [95:0] ch_data      = '0;
    logic [15:0] rx_cmd;
    logic        rx_cmd_valid, frame_done, frame_error, busy;
    logic [1:0]  state;

    ads131_spi_responder_if spi_if ();

    ads131_spi_responder #(.WORD_BITS(WB), .FRAME_WORDS(FW), .SYNC_STAGES(2)) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .spi          (spi_if.slave),
        .status_word  (status_word),
        .ch_data      (ch_data),
        .rx_cmd       (rx_cmd),
        .rx_cmd_valid (rx_cmd_valid),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .busy         (busy),
        .state        (state)
    );

    always #10 system_clock = ~system_clock;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, err_cnt = 0, valid_cnt = 0;

    always @(posedge system_clock) begin
        if (frame_done)   done_cnt  <= done_cnt + 1;
        if (frame_error)  err_cnt   <= err_cnt + 1;
        if (rx_cmd_valid) valid_cnt <= valid_cnt + 1;
    end

    logic [15:0] resp_model   = 16'hFF04;
    logic [15:0] rx_cmd_model = 16'h0000;
    logic        got_bits [TOT+8];
    logic        mosi_bits [TOT+8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_resp(input logic [15:0] cmd, input logic [15:0] stat);
        if (cmd == 16'h0011) return 16'hFF04;
        if (cmd inside {16'h0655, 16'h0555, 16'h0022, 16'h0033}) return cmd;
        return stat;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic send_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_if.SPI_SCLK = 1'b1;
            spi_if.SPI_MOSI = mosi_bits[i];
            clks(HALF);
            got_bits[i] = spi_if.SPI_MISO;
            spi_if.SPI_SCLK = 1'b0;
            clks(HALF);
        end
    endtask

    task automatic do_frame(input string tag, input logic [15:0] cmd, input int nbits, input logic [15:0] stat);
        int d0, e0, v0;
        logic [31:0] w_obs, w_exp;
        logic [15:0] rnd;
        status_word = stat;
        for (int i = 0; i < TOT + 8; i++) mosi_bits[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) mosi_bits[i] = cmd[15-i];
        d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
        spi_if.SPI_CS = 1'b0;
        clks(HALF);
        chk({tag, "_miso_pre"}, 32'(spi_if.SPI_MISO), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        send_bits(nbits);
        spi_if.SPI_CS = 1'b1;
        clks(10);
        for (int w = 0; w < FW; w++) begin
            if ((w + 1) * WB <= nbits) begin
                for (int b = 0; b < WB; b++) w_obs[31-b] = got_bits[w*WB+b];
                w_exp = (w == 0) ? {resp_model, 16'h0000} : {ch_data[24*(w-1) +: 24], 8'h00};
                chk($sformatf("%s_word%0d", tag, w), w_obs, w_exp);
            end
        end
        for (int i = TOT; i < nbits; i++) chk({tag, "_miso_past_end"}, 32'(got_bits[i]), 32'h0);
        if (nbits >= WB) rx_cmd_model = cmd;
        chk({tag, "_done"},  32'(done_cnt - d0),  (nbits >= TOT) ? 32'h1 : 32'h0);
        chk({tag, "_error"}, 32'(err_cnt - e0),   (nbits >= TOT) ? 32'h0 : 32'h1);
        chk({tag, "_valid"}, 32'(valid_cnt - v0), (nbits >= WB)  ? 32'h1 : 32'h0);
        chk({tag, "_rx_cmd"}, 32'(rx_cmd), 32'(rx_cmd_model));
        chk({tag, "_idle"}, {30'h0, state}, 32'h0);
        if (nbits >= TOT) resp_model = model_resp(cmd, stat);
        rnd = 16'($urandom);
        rnd = rnd;
    endtask

    logic [15:0] pool [7];
    logic [15:0] rc, rs;
    int          nb;

    initial begin
        spi_if.SPI_SCLK = 1'b0;
        spi_if.SPI_CS   = 1'b1;
        spi_if.SPI_MOSI = 1'b0;
        ch_data = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
        clks(4);
        chk("rst_miso", 32'(spi_if.SPI_MISO), 32'h0);
        chk("rst_rx_cmd", 32'(rx_cmd), 32'h0);
        chk("rst_pulses", {29'h0, rx_cmd_valid, frame_done, frame_error}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_state", {30'h0, state}, 32'h0);
        reset_n = 1'b1;
        clks(4);

        do_frame("null_first", 16'h0000, TOT, 16'($urandom));
        do_frame("unlock", 16'h0655, TOT, 16'($urandom));
        do_frame("after_unlock", 16'h0000, TOT, 16'h2230);
        do_frame("after_null_status", 16'h0000, TOT, 16'($urandom));
        ch_data[23:0]  = 24'hABCDEF;
        ch_data[95:72] = 24'h123456;
        do_frame("ch_pattern", 16'h0011, TOT, 16'($urandom));
        do_frame("lock_short", 16'h0555, 40, 16'($urandom));
        do_frame("after_short", 16'h0000, TOT, 16'($urandom));
        do_frame("tiny_frame", 16'h0022, 10, 16'($urandom));
        do_frame("overrun", 16'h0033, TOT + 6, 16'($urandom));

        // Reset in the middle of a frame abandons it.
        mosi_bits[0] = 1'b0;
        spi_if.SPI_CS = 1'b0;
        clks(HALF);
        send_bits(70);
        reset_n = 1'b0;
        clks(3);
        chk("midrst_miso", 32'(spi_if.SPI_MISO), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rx_cmd", 32'(rx_cmd), 32'h0);
        spi_if.SPI_CS   = 1'b1;
        spi_if.SPI_SCLK = 1'b0;
        clks(4);
        reset_n = 1'b1;
        resp_model   = 16'hFF04;
        rx_cmd_model = 16'h0000;
        clks(4);
        do_frame("post_reset", 16'h0000, TOT, 16'($urandom));

        pool[0] = 16'h0000; pool[1] = 16'h0011; pool[2] = 16'h0655; pool[3] = 16'h0555;
        pool[4] = 16'h0022; pool[5] = 16'h0033; pool[6] = 16'h0000;
        for (int f = 0; f < 5; f++) begin
            rc = pool[$urandom_range(0, 6)];
            if (f == 6 || $urandom_range(0, 3) == 0) rc = 16'($urandom);
            rs = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOT - 1)) : TOT;
            ch_data = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
            do_frame($sformatf("rand%0d", f), rc, nb, rs);
        end
        do_frame("final_null", 16'h0000, TOT, 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
